// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer: serialises EPC/Cause/Status/BadVAddr writes over the
// shared CP0 write bus, then pulses a PC redirect. Optional macro: CP0_EXC_BADVADDR_EN.
module cp0_exc_seq #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_vaddr,
    input  logic [31:0] int_pc,
    input  logic [5:0]  hw_int,
    input  logic        eret_req,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        exc_ack,
    output logic        eret_ack,
    output logic        busy,
    output logic [31:0] cp0_wdata,
    output logic        we_epc,
    output logic        we_cause,
    output logic        we_status,
    output logic        we_badVAddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_STATUS, W_BADV, W_ERET, REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic [5:0]  hwint_q, hwint_d;
    logic        old_exl_q, old_exl_d;
    logic [31:0] status_q, status_d;
    logic [15:0] cause_hi_q, cause_hi_d;
    logic [1:0]  cause_ip_q, cause_ip_d;
    logic        is_eret_q, is_eret_d;

    logic [31:0] wdata_q, wdata_d;
    logic        we_epc_q, we_epc_d;
    logic        we_cause_q, we_cause_d;
    logic        we_status_q, we_status_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rpc_q, rpc_d;

    logic        int_pend;
    logic        badv_needed;

`ifdef CP0_EXC_BADVADDR_EN
    logic [31:0] vaddr_q, vaddr_d;
    logic        we_badv_q, we_badv_d;
    assign badv_needed = (code_q >= 5'd1) && (code_q <= 5'd5);
    assign we_badVAddr = we_badv_q;
`else
    logic unused_vaddr;
    assign unused_vaddr = ^exc_vaddr;
    assign badv_needed  = 1'b0;
    assign we_badVAddr  = 1'b0;
`endif

    // Cause IP/ExcCode fields are rebuilt from latched state, so their live bits are unused.
    logic unused_cause;
    assign unused_cause = ^{cp0_cause[15:10], cp0_cause[7:0]};

    assign int_pend = cp0_status[0] & ~cp0_status[1] & (|(hw_int & cp0_status[15:10]));

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        hwint_d    = hwint_q;
        old_exl_d  = old_exl_q;
        status_d   = status_q;
        cause_hi_d = cause_hi_q;
        cause_ip_d = cause_ip_q;
        is_eret_d  = is_eret_q;
`ifdef CP0_EXC_BADVADDR_EN
        vaddr_d    = vaddr_q;
        we_badv_d  = 1'b0;
`endif
        exc_ack     = 1'b0;
        eret_ack    = 1'b0;
        wdata_d     = 32'h0;
        we_epc_d    = 1'b0;
        we_cause_d  = 1'b0;
        we_status_d = 1'b0;
        rvalid_d    = 1'b0;
        rpc_d       = 32'h0;

        case (state_q)
            IDLE: begin
                if (exc_req || int_pend) begin
                    exc_ack    = 1'b1;
                    is_eret_d  = 1'b0;
                    hwint_d    = hw_int;
                    old_exl_d  = cp0_status[1];
                    status_d   = cp0_status;
                    cause_hi_d = cp0_cause[31:16];
                    cause_ip_d = cp0_cause[9:8];
                    if (exc_req) begin
                        code_d = exc_code;
                        epc_d  = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                        bd_d   = exc_bd;
`ifdef CP0_EXC_BADVADDR_EN
                        vaddr_d = exc_vaddr;
`endif
                    end else begin
                        code_d = 5'd0;
                        epc_d  = int_pc;
                        bd_d   = 1'b0;
                    end
                    // Nested exception: EPC already holds the outer return address.
                    state_d = cp0_status[1] ? W_CAUSE : W_EPC;
                end else if (eret_req) begin
                    eret_ack  = 1'b1;
                    is_eret_d = 1'b1;
                    epc_d     = cp0_epc;
                    status_d  = cp0_status;
                    state_d   = W_ERET;
                end
            end
            W_EPC:    state_d = W_CAUSE;
            W_CAUSE:  state_d = W_STATUS;
            W_STATUS: state_d = badv_needed ? W_BADV : REDIRECT;
            W_BADV:   state_d = REDIRECT;
            W_ERET:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        case (state_d)
            W_EPC: begin
                wdata_d  = epc_d;
                we_epc_d = 1'b1;
            end
            W_CAUSE: begin
                wdata_d    = {(old_exl_d ? cause_hi_d[15] : bd_d), cause_hi_d[14:0],
                              hwint_d, cause_ip_d, 1'b0, code_d, 2'b00};
                we_cause_d = 1'b1;
            end
            W_STATUS: begin
                wdata_d     = status_d | 32'h2;
                we_status_d = 1'b1;
            end
`ifdef CP0_EXC_BADVADDR_EN
            W_BADV: begin
                wdata_d   = vaddr_d;
                we_badv_d = 1'b1;
            end
`endif
            W_ERET: begin
                wdata_d     = status_d & ~32'h2;
                we_status_d = 1'b1;
            end
            REDIRECT: begin
                rvalid_d = 1'b1;
                rpc_d    = is_eret_d ? epc_d : EXC_VECTOR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= 5'd0;
            epc_q       <= 32'h0;
            bd_q        <= 1'b0;
            hwint_q     <= 6'd0;
            old_exl_q   <= 1'b0;
            status_q    <= 32'h0;
            cause_hi_q  <= 16'h0;
            cause_ip_q  <= 2'd0;
            is_eret_q   <= 1'b0;
            wdata_q     <= 32'h0;
            we_epc_q    <= 1'b0;
            we_cause_q  <= 1'b0;
            we_status_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rpc_q       <= 32'h0;
`ifdef CP0_EXC_BADVADDR_EN
            vaddr_q     <= 32'h0;
            we_badv_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            epc_q       <= epc_d;
            bd_q        <= bd_d;
            hwint_q     <= hwint_d;
            old_exl_q   <= old_exl_d;
            status_q    <= status_d;
            cause_hi_q  <= cause_hi_d;
            cause_ip_q  <= cause_ip_d;
            is_eret_q   <= is_eret_d;
            wdata_q     <= wdata_d;
            we_epc_q    <= we_epc_d;
            we_cause_q  <= we_cause_d;
            we_status_q <= we_status_d;
            rvalid_q    <= rvalid_d;
            rpc_q       <= rpc_d;
`ifdef CP0_EXC_BADVADDR_EN
            vaddr_q     <= vaddr_d;
            we_badv_q   <= we_badv_d;
`endif
        end
    end

    assign busy           = (state_q != IDLE);
    assign cp0_wdata      = wdata_q;
    assign we_epc         = we_epc_q;
    assign we_cause       = we_cause_q;
    assign we_status      = we_status_q;
    assign redirect_valid = rvalid_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: doc/cp0_exc_seq.md
# cp0_exc_seq

Exception/ERET sequencer for the CP0 register file. It accepts synchronous exception reports, pending hardware interrupts and ERET requests from the pipeline. Because the CP0 register file has a single shared write-data bus, it serialises the EPC/Cause/Status/BadVAddr updates one register per cycle. It then issues a one-cycle PC redirect to the exception vector or to EPC.

## Interface
- EXC_VECTOR, 32'h8000_0180, general exception entry PC
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- exc_req  in  1  pipeline reports a synchronous exception
- exc_code  in  5  ExcCode of the reported exception
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_vaddr  in  32  faulting virtual address
- int_pc  in  32  PC of the next instruction to commit (interrupt EPC)
- hw_int  in  6  hardware interrupt lines, level-sensitive
- eret_req  in  1  ERET at commit
- cp0_status, cp0_cause, cp0_epc  in  32  current CP0 register values
- exc_ack  out  1  combinational; request accepted this cycle
- eret_ack  out  1  combinational; ERET accepted this cycle
- busy  out  1  sequence in progress; pipeline holds commit and must not issue MTC0
- cp0_wdata  out  32  registered; shared write data to the CP0 register file
- we_epc, we_cause, we_status, we_badVAddr  out  1 each  registered; at most one high per cycle
- redirect_valid  out  1  registered one-cycle pulse
- redirect_pc  out  32  registered; valid while redirect_valid is high

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, W_BADV, W_ERET, REDIRECT.
- The accepted request is selected in IDLE with priority exc_req > interrupt > eret_req. Non-IDLE states ignore all requests; no ack is issued.
- Interrupt pending = cp0_status[0] (IE) & ~cp0_status[1] (EXL) & |(hw_int & cp0_status[15:10]). When accepted:
  - exc_code is 0
  - EPC = int_pc
  - BD = 0
  - exc_ack is high.
- On acceptance the block latches the following:
  - exc_code
  - EPC value: exc_pc - 4 if exc_bd, else exc_pc
  - BD
  - exc_vaddr
  - hw_int
  - EXL at acceptance, as old_exl
  - cp0_status
  - cp0_cause
- Exception path: IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> [W_BADV] -> REDIRECT -> IDLE.
  - If old_exl = 1, W_EPC is skipped: IDLE goes directly to W_CAUSE, and the BD bit keeps its latched Cause value.
  - W_EPC: cp0_wdata = EPC value, we_epc = 1.
  - W_CAUSE: cp0_wdata = {BD, cause[30:16], hw_int latched, cause[9:8], 1'b0, exc_code, 2'b00}, we_cause = 1.
  - W_STATUS: cp0_wdata = latched status | 32'h2, we_status = 1.
  - W_BADV: entered only for exc_code 1-5. cp0_wdata = latched exc_vaddr, we_badVAddr = 1.
  - REDIRECT: redirect_valid = 1, redirect_pc = EXC_VECTOR, all we low.
- ERET path: IDLE -> W_ERET -> REDIRECT -> IDLE.
  - W_ERET: cp0_wdata = latched status & ~32'h2, we_status = 1.
  - REDIRECT: redirect_pc = cp0_epc, latched at acceptance.
- busy = (state != IDLE).
- All arithmetic is 32-bit modulo. exc_pc = 0 with exc_bd gives EPC 32'hFFFF_FFFC.

## Timing
- Reset values: state IDLE, busy 0, all we_* 0, cp0_wdata 0, redirect_valid 0, redirect_pc 0.
- Reset asserted mid-sequence: the block is back in IDLE with all outputs at reset values after the next edge. Remaining writes are dropped. CP0 registers already written stay written.
- Latency from the acceptance cycle T:
  - Exception, old_exl = 0, no BadVAddr: writes occur at T+1..T+3, redirect_valid at T+4, IDLE again at T+5.
  - Each of BadVAddr (+1) and the EPC skip (-1) shifts the redirect accordingly.
  - ERET: write at T+1, redirect at T+2.
- Requests are acks only in IDLE and are not queued. The pipeline holds exc_req or eret_req until acknowledged.
- exc_req and eret_req in the same IDLE cycle: the exception wins; eret_ack stays 0.
- An interrupt becomes pending while busy: it is evaluated again in IDLE using the updated status, so EXL = 1 masks it.

## Configuration
- CP0_EXC_BADVADDR_EN:
  - Defined: W_BADV is used for exc_code 1-5 as specified above.
  - Undefined: W_BADV is never entered, we_badVAddr is constant 0, and exc_vaddr is ignored.

## Test plan
- Reset asserted -> all outputs 0, busy 0.
- exc_req, code 8, exc_pc 32'h0000_1000, exc_bd 0, status 32'h0000_FF01, cause 0:
  - T+1: we_epc with 32'h1000
  - T+2: we_cause with 32'h0000_0020
  - T+3: we_status with 32'h0000_FF03
  - T+4: redirect to 32'h8000_0180.
- exc_req, code 4, exc_bd 1, exc_pc 32'h2004, exc_vaddr 32'hDEAD_BEE1, with macro defined:
  - EPC 32'h2000
  - Cause bit31 = 1
  - we_badVAddr with 32'hDEAD_BEE1 at T+4
  - redirect at T+5.
  - Without the macro: redirect at T+4.
- hw_int 6'b000001, status 32'h0000_0401 -> exc_ack, EPC = int_pc, Cause 32'h0000_0400. With status EXL set -> no ack.
- eret_req, status 32'h0000_FF03, epc 32'h0000_3000 -> T+1 we_status 32'h0000_FF01, T+2 redirect to 32'h3000.
- exc_req, eret_req and a pending interrupt in the same cycle -> exception taken, eret_ack 0. rst at T+2 -> IDLE at T+3 with no further writes.
